spi_ram_arbiter: RTL

- Command sequencer between the SPI slave and the single-port 256x8 RAM.
- Decodes each 10-bit SPI word {cmd[1:0], payload[7:0]} into address-latch, write and read operations.
- Shares the RAM with a second local host port, arbitrating one access per grant.
- Returns read data to the SPI slave via tx_data/tx_valid.

---
 rtl/spi_ram_arbiter_if.sv | 36 +++
 rtl/spi_ram_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/spi_ram_arbiter_if.sv
// Bus bundle for spi_ram_arbiter: SPI word/return path, local host port and RAM port.
// slave is the arbiter's view; master is the surrounding environment's view.
interface spi_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [9:0]        rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_dout;
  logic              spi_ovf;

  modport slave (
    input  rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, mem_dout,
    output tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, mem_addr, mem_din, mem_we,
           mem_re, spi_ovf
  );

  modport master (
    output rx_data, rx_valid, host_req, host_we, host_addr, host_wdata, mem_dout,
    input  tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, mem_addr, mem_din, mem_we,
           mem_re, spi_ovf
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Command sequencer between an SPI slave and a single-port RAM shared with a local host port.
// Optional macro ADDR_AUTOINC_EN: post-increment wr_addr/rd_addr after each captured SPI op.
module spi_ram_arbiter #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned HOST_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_ram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StAccess, StRdata} state_e;

  localparam logic [1:0] CmdWrAddr = 2'b00;
  localparam logic [1:0] CmdWrite  = 2'b01;
  localparam logic [1:0] CmdRdAddr = 2'b10;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic              slot_valid_q, slot_valid_d, slot_we_q, slot_we_d;
  logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic [DATA_W-1:0] slot_data_q, slot_data_d;
  logic              spi_ovf_q, spi_ovf_d;
  logic              last_host_q, win_host_q, acc_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q, tx_data_q, host_rdata_q;
  logic              mem_we_q, mem_re_q, host_gnt_q, tx_valid_q, host_rvalid_q;

  logic [1:0]        cmd;
  logic [7:0]        payload;
  logic              data_cmd, accept;
  logic              grant, grant_host, grant_we;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;

  assign cmd      = bus.rx_data[9:8];
  assign payload  = bus.rx_data[7:0];
  assign data_cmd = bus.rx_valid & cmd[0];
  assign accept   = data_cmd & ~slot_valid_q;

  // Address resolved at capture, so later address commands leave a pending op alone.
  always_comb begin
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    slot_valid_d = slot_valid_q;
    slot_we_d    = slot_we_q;
    slot_addr_d  = slot_addr_q;
    slot_data_d  = slot_data_q;
    spi_ovf_d    = spi_ovf_q | (data_cmd & slot_valid_q);
    if (bus.rx_valid && cmd == CmdWrAddr) wr_addr_d = payload[ADDR_W-1:0];
    if (bus.rx_valid && cmd == CmdRdAddr) rd_addr_d = payload[ADDR_W-1:0];
    if (accept) begin
      slot_valid_d = 1'b1;
      slot_we_d    = (cmd == CmdWrite);
      slot_addr_d  = (cmd == CmdWrite) ? wr_addr_q : rd_addr_q;
      slot_data_d  = payload[DATA_W-1:0];
`ifdef ADDR_AUTOINC_EN
      if (cmd == CmdWrite) wr_addr_d = wr_addr_q + ADDR_W'(1);
      else                 rd_addr_d = rd_addr_q + ADDR_W'(1);
`endif
    end else if (state_q == StAccess && !win_host_q) begin
      slot_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_host = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (slot_valid_q || bus.host_req) begin
          grant   = 1'b1;
          state_d = StAccess;
          if (slot_valid_q && bus.host_req) grant_host = (HOST_PRIO != 0) || !last_host_q;
          else                              grant_host = bus.host_req;
        end
      end
      StAccess: state_d = acc_we_q ? StIdle : StRdata;
      StRdata:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    grant_we   = grant_host ? bus.host_we    : slot_we_q;
    grant_addr = grant_host ? bus.host_addr  : slot_addr_q;
    grant_data = grant_host ? bus.host_wdata : slot_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      slot_valid_q  <= 1'b0;
      slot_we_q     <= 1'b0;
      slot_addr_q   <= '0;
      slot_data_q   <= '0;
      spi_ovf_q     <= 1'b0;
      last_host_q   <= 1'b1;  // "host granted last" so SPI takes the first tie
      win_host_q    <= 1'b0;
      acc_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      host_gnt_q    <= 1'b0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      slot_valid_q  <= slot_valid_d;
      slot_we_q     <= slot_we_d;
      slot_addr_q   <= slot_addr_d;
      slot_data_q   <= slot_data_d;
      spi_ovf_q     <= spi_ovf_d;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      host_gnt_q    <= 1'b0;
      tx_valid_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      if (grant) begin
        last_host_q <= grant_host;
        win_host_q  <= grant_host;
        acc_we_q    <= grant_we;
        host_gnt_q  <= grant_host;
        mem_we_q    <= grant_we;
        mem_re_q    <= ~grant_we;
        mem_addr_q  <= grant_addr;
        if (grant_we) mem_din_q <= grant_data;
      end
      if (state_q == StRdata) begin
        if (win_host_q) begin
          host_rdata_q  <= bus.mem_dout;
          host_rvalid_q <= 1'b1;
        end else begin
          tx_data_q  <= bus.mem_dout;
          tx_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.host_gnt    = host_gnt_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_din     = mem_din_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_re      = mem_re_q;
  assign bus.spi_ovf     = spi_ovf_q;
endmodule
